word_unpacker: RTL and testbench
================================

WORD_UNPACKER -- requirements
Module: word_unpacker

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of each input word.
REQ-002 Parameter NUM_OUT, default 200, SHALL set the width of the output vector; NUM_OUT >= 1.
REQ-003 Parameter LSB_FIRST, default 1, SHALL set placement order: 1 = first word at bit 0, 0 = first word at bit NUM_OUT-1.
REQ-004 Derived: NWORDS = ceil(NUM_OUT/DATA_WIDTH); REM = NUM_OUT - (NWORDS-1)*DATA_WIDTH (1..DATA_WIDTH); defaults give NWORDS=7, REM=8.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 i0  input  1  source select: 0 = i1, 1 = i2; sampled only on an accepted word.
REQ-008 i1  input  DATA_WIDTH  data word source A.
REQ-009 i2  input  DATA_WIDTH  data word source B.
REQ-010 in_valid  input  1  input word present.
REQ-011 in_ready  output  1  block can accept a word.
REQ-012 flush  input  1  synchronous abort of a partial fill.
REQ-013 o  output  NUM_OUT  assembled output vector, registered.
REQ-014 o_valid  output  1  o is complete and stable.
REQ-015 o_ready  input  1  consumer takes o.
REQ-016 o_count  output  clog2(NWORDS+1)  number of words held in the current fill.

Function
REQ-017 The block SHALL be a two-state FSM: FILL (in_ready=1, o_valid=0) and HOLD (in_ready=0, o_valid=1); outputs decoded from registered state only.
REQ-018 Accept = in_valid & in_ready; on accept the word (i0 ? i2 : i1) SHALL be written into o at slot k = o_count, and o_count SHALL increment.
REQ-019 LSB_FIRST=1: slot k < NWORDS-1 SHALL occupy o[k*DATA_WIDTH +: DATA_WIDTH]; slot NWORDS-1 SHALL occupy o[NUM_OUT-1 -: REM] with word bits [REM-1:0].
REQ-020 LSB_FIRST=0: slot k < NWORDS-1 SHALL occupy o[NUM_OUT-1-k*DATA_WIDTH -: DATA_WIDTH]; slot NWORDS-1 SHALL occupy o[REM-1:0] with word bits [REM-1:0].
REQ-021 Word bits above REM in the last slot SHALL be discarded; bits of o outside the written slot SHALL hold.
REQ-022 Accept of slot NWORDS-1 SHALL move FILL->HOLD; o_valid SHALL rise the next cycle with o_count=NWORDS (latency: 1 cycle after last accept).
REQ-023 In HOLD, o and o_count SHALL be stable; in_valid SHALL be ignored.
REQ-024 HOLD with o_ready=1 SHALL move to FILL with o_count=0; no word is accepted in that same cycle (one-cycle bubble).
REQ-025 HOLD with o_ready=0 SHALL remain in HOLD indefinitely.
REQ-026 flush=1 in FILL SHALL set o_count=0 and discard any same-cycle accept; o SHALL hold its contents.
REQ-027 flush=1 in HOLD SHALL have no effect (o_ready alone releases HOLD).
REQ-028 NWORDS=1 SHALL work: every accept goes FILL->HOLD.
REQ-029 o_count SHALL never exceed NWORDS and never wrap.

Reset
REQ-030 rst=1 SHALL immediately, without clk, force state FILL, o_count=0, o=0, o_valid=0, in_ready=1.
REQ-031 rst asserted mid-fill or in HOLD SHALL discard all partial/complete data; the first accept after deassertion is slot 0.
REQ-032 Release of rst SHALL be synchronous to clk; no accept occurs in the cycle rst deasserts.

Verification (defaults unless stated)
REQ-033 Reset: rst pulse with no clk -> o=0, o_valid=0, in_ready=1, o_count=0.
REQ-034 Fill: 7 accepts with i0=0, i1=32'h0000000k (k=0..6), o_ready=0 -> one cycle after 7th accept o_valid=1, o[31:0]=0, o[63:32]=1, o[199:192]=8'h06, in_ready=0; holds 10 cycles.
REQ-035 Select/truncation: 6 words i1=32'hFFFFFFFF, 7th i0=1, i2=32'hABCDEF5A -> o[199:192]=8'h5A, o[191:0] all ones.
REQ-036 LSB_FIRST=0: words 32'h11111111, 32'h22222222, ..., 7th 32'h000000C3 -> o[199:168]=32'h11111111, o[7:0]=8'hC3.
REQ-037 Flush/backpressure: 3 accepts, flush with in_valid=1 -> o_count=0, word dropped; then 7 accepts, o_ready=1 in HOLD -> next cycle o_valid=0, o_count=0, in_ready=1.
REQ-038 Reset mid-operation: rst after 4 accepts -> o=0, o_count=0; 7 new accepts produce o_valid exactly one cycle after the 7th.

Source files
------------

// File: rtl/word_unpacker.sv
// Purpose : assembles NWORDS input words (from one of two sources) into one NUM_OUT-bit vector.
// Latency : o_valid rises one cycle after the last word of a fill is accepted.
// Backpr. : in_ready low while a completed vector is held; o_ready releases it with a one-cycle bubble.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   i0, i1, i2           source select (0 = i1, 1 = i2) and the two data word sources
//   in_valid, in_ready   input word handshake
//   flush                synchronous abort of a partial fill (ignored while holding)
//   o, o_valid, o_ready  assembled vector and its handshake
//   o_count              number of words held in the current fill
module word_unpacker #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_OUT    = 200,
   parameter int LSB_FIRST  = 1,
   localparam int NWORDS    = (NUM_OUT + DATA_WIDTH - 1) / DATA_WIDTH,
   localparam int CW        = $clog2(NWORDS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i0,
   input  logic [DATA_WIDTH-1:0] i1,
   input  logic [DATA_WIDTH-1:0] i2,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  flush,
   output logic [NUM_OUT-1:0]    o,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic [CW-1:0]         o_count
);

   // Width of the last (possibly partial) slot, 1..DATA_WIDTH.
   localparam int REM = NUM_OUT - (NWORDS - 1) * DATA_WIDTH;

   typedef enum logic {FILL, HOLD} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [NUM_OUT-1:0]    o_q, o_d;
   logic [DATA_WIDTH-1:0] word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FILL;
         cnt_q   <= '0;
         o_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         o_q     <= o_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      o_d     = o_q;
      word    = i0 ? i2 : i1;

      unique case (state_q)
         FILL: begin
            // Flush wins over a same-cycle accept; the vector keeps its old bits.
            if (flush) begin
               cnt_d = '0;
            end else if (in_valid) begin
               // Full-width slots; only the slot matching the current count is written.
               for (int k = 0; k < NWORDS - 1; k++) begin
                  if (cnt_q == CW'(k)) begin
                     if (LSB_FIRST != 0)
                        o_d[k*DATA_WIDTH +: DATA_WIDTH] = word;
                     else
                        o_d[NUM_OUT-1-k*DATA_WIDTH -: DATA_WIDTH] = word;
                  end
               end
               // Last slot takes only the low REM bits of the word and completes the fill.
               if (cnt_q == CW'(NWORDS - 1)) begin
                  if (LSB_FIRST != 0)
                     o_d[NUM_OUT-1 -: REM] = word[REM-1:0];
                  else
                     o_d[REM-1:0] = word[REM-1:0];
                  state_d = HOLD;
               end
               cnt_d = cnt_q + 1'b1;
            end
         end
         HOLD: begin
            // No accept in the release cycle: in_ready is decoded from HOLD.
            if (o_ready) begin
               state_d = FILL;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = FILL;
            cnt_d   = '0;
         end
      endcase
   end

   assign in_ready = (state_q == FILL);
   assign o_valid  = (state_q == HOLD);
   assign o        = o_q;
   assign o_count  = cnt_q;

endmodule

// File: tb/tb_word_unpacker.sv
// Purpose : scoreboard bench for word_unpacker; two instances (LSB-first and MSB-first) share stimulus.
// Latency : expected vectors carry the cycle in which o_valid must first be seen.
// Backpr. : o_ready driven explicitly by the directed sequence.
module tb_word_unpacker;

   typedef struct {
      logic [199:0] v;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         i0 = 1'b0;
   logic [31:0]  i1 = '0;
   logic [31:0]  i2 = '0;
   logic         in_valid = 1'b0;
   logic         flush = 1'b0;
   logic         o_ready = 1'b0;

   logic         ira, irb, ova, ovb;
   logic [199:0] oa, ob;
   logic [2:0]   oca, ocb;

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;

   exp_t         qa[$];
   exp_t         qb[$];
   exp_t         ea, eb, ma, mb;
   logic [31:0]  wv [7];
   logic         pva = 1'b0;
   logic         pvb = 1'b0;

   word_unpacker #(.DATA_WIDTH(32), .NUM_OUT(200), .LSB_FIRST(1)) dut_a (
      .clk(clk), .rst(rst), .i0(i0), .i1(i1), .i2(i2),
      .in_valid(in_valid), .in_ready(ira), .flush(flush),
      .o(oa), .o_valid(ova), .o_ready(o_ready), .o_count(oca)
   );

   word_unpacker #(.DATA_WIDTH(32), .NUM_OUT(200), .LSB_FIRST(0)) dut_b (
      .clk(clk), .rst(rst), .i0(i0), .i1(i1), .i2(i2),
      .in_valid(in_valid), .in_ready(irb), .flush(flush),
      .o(ob), .o_valid(ovb), .o_ready(o_ready), .o_count(ocb)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitors: on each rising o_valid, pop the expected vector and compare.
   always @(negedge clk) begin
      if (ova && !pva) begin
         if (qa.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_valid actual=1 required=0");
         end else begin
            ma = qa.pop_front();
            chk("a_o", oa, ma.v);
            chk("a_latency_cyc", 200'(cyc), 200'(ma.cyc));
            chk("a_count_full", 200'(oca), 200'(3'd7));
            chk("a_in_ready_hold", 200'(ira), 200'(1'b0));
         end
      end
      pva = ova;
   end

   always @(negedge clk) begin
      if (ovb && !pvb) begin
         if (qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_valid actual=1 required=0");
         end else begin
            mb = qb.pop_front();
            chk("b_o", ob, mb.v);
            chk("b_latency_cyc", 200'(cyc), 200'(mb.cyc));
            chk("b_count_full", 200'(ocb), 200'(3'd7));
         end
      end
      pvb = ovb;
   end

   // One accept; when last is set, expected vectors are queued with the due cycle.
   task automatic send(input logic sel, input logic [31:0] w, input logic last);
      @(negedge clk);
      i0       = sel;
      i1       = sel ? ~w : w;
      i2       = sel ? w : ~w;
      in_valid = 1'b1;
      if (last) begin
         ea.cyc = cyc + 1;
         eb.cyc = cyc + 1;
         qa.push_back(ea);
         qb.push_back(eb);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic fill7(input logic [6:0] sel);
      ea.v = {wv[6][7:0], wv[5], wv[4], wv[3], wv[2], wv[1], wv[0]};
      eb.v = {wv[0], wv[1], wv[2], wv[3], wv[4], wv[5], wv[6][7:0]};
      for (int k = 0; k < 7; k++) send(sel[k], wv[k], k == 6);
   endtask

   // Release HOLD with a word offered in the same cycle; it must not be taken.
   task automatic release_hold(input string tag);
      @(negedge clk);
      o_ready  = 1'b1;
      in_valid = 1'b1;
      i0       = 1'b0;
      i1       = 32'h5555AAAA;
      @(negedge clk);
      chk({tag, "_rel_valid"}, 200'(ova), 200'(1'b0));
      chk({tag, "_rel_count"}, 200'(oca), 200'(3'd0));
      chk({tag, "_rel_in_ready"}, 200'(ira), 200'(1'b1));
      o_ready  = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      // Asynchronous reset before any clock edge.
      #1 rst = 1'b1;
      #1;
      chk("rst_o", oa, 200'd0);
      chk("rst_valid", 200'(ova), 200'(1'b0));
      chk("rst_in_ready", 200'(ira), 200'(1'b1));
      chk("rst_count", 200'(oca), 200'(3'd0));
      chk("rst_o_b", ob, 200'd0);
      @(negedge clk);
      rst = 1'b0;

      // Basic fill, then hold for 10 cycles with in_valid and flush ignored.
      for (int k = 0; k < 7; k++) wv[k] = 32'(k);
      fill7(7'b0000000);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("hold_valid", 200'(ova), 200'(1'b1));
         chk("hold_in_ready", 200'(ira), 200'(1'b0));
         chk("hold_count", 200'(oca), 200'(3'd7));
         chk("hold_lo", 200'(oa[31:0]), 200'(32'h0));
         chk("hold_w1", 200'(oa[63:32]), 200'(32'h1));
         chk("hold_top", 200'(oa[199:192]), 200'(8'h06));
         in_valid = 1'b1;
         i1       = 32'hBAD0BAD0;
         flush    = (c == 3);
      end
      flush    = 1'b0;
      in_valid = 1'b0;
      release_hold("fill");

      // Source select and last-slot truncation.
      for (int k = 0; k < 6; k++) wv[k] = 32'hFFFFFFFF;
      wv[6] = 32'hABCDEF5A;
      fill7(7'b1000000);
      @(negedge clk);
      chk("sel_top", 200'(oa[199:192]), 200'(8'h5A));
      chk("sel_low_ones", 200'(oa[191:0]), {8'h00, {192{1'b1}}});
      release_hold("sel");

      // MSB-first ordering (instance b).
      for (int k = 0; k < 6; k++) wv[k] = 32'h11111111 * (k + 1);
      wv[6] = 32'h000000C3;
      fill7(7'b0000000);
      @(negedge clk);
      chk("msb_top", 200'(ob[199:168]), 200'(32'h11111111));
      chk("msb_low", 200'(ob[7:0]), 200'(8'hC3));
      release_hold("msb");

      // Flush after 3 accepts with a word offered in the same cycle.
      for (int k = 0; k < 3; k++) send(1'b0, 32'hA0A0A000 + 32'(k), 1'b0);
      @(negedge clk);
      chk("pre_flush_count", 200'(oca), 200'(3'd3));
      flush    = 1'b1;
      in_valid = 1'b1;
      i0       = 1'b0;
      i1       = 32'hDEADBEEF;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_count", 200'(oca), 200'(3'd0));
      chk("flush_slot3_held", 200'(oa[127:96]), 200'(32'h44444444));
      chk("flush_slot0_kept", 200'(oa[31:0]), 200'(32'hA0A0A000));
      for (int k = 0; k < 7; k++) wv[k] = 32'hC0DE0000 + 32'(k);
      fill7(7'b0000000);
      release_hold("flush");

      // Reset in the middle of a fill.
      for (int k = 0; k < 4; k++) send(1'b0, 32'h12340000 + 32'(k), 1'b0);
      @(negedge clk);
      chk("mid_count", 200'(oca), 200'(3'd4));
      rst = 1'b1;
      #1;
      chk("midrst_o", oa, 200'd0);
      chk("midrst_count", 200'(oca), 200'(3'd0));
      chk("midrst_valid", 200'(ova), 200'(1'b0));
      chk("midrst_in_ready", 200'(ira), 200'(1'b1));
      chk("midrst_o_b", ob, 200'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 7; k++) wv[k] = 32'h0F0F0000 + 32'(k);
      fill7(7'b0000000);
      release_hold("rst");

      repeat (3) @(negedge clk);
      chk("a_queue_drained", 200'(qa.size()), 200'd0);
      chk("b_queue_drained", 200'(qb.size()), 200'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
